// File: rtl/disp_scan_sched.sv
// disp_scan_sched: 8-digit 7-seg scan scheduler with ghost gaps, leading-zero blanking, blink and dp.
module disp_scan_sched #(
  parameter int DWELL_CYCLES = 100000,
  parameter int GHOST_CYCLES = 1000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digits,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  blink_mask,
  input  logic        lz_blank_en,
  output logic [7:0]  an,
  output logic [3:0]  dec_code,
  output logic        dp_n,
  output logic        frame_start
);
  localparam int TMAX = DWELL_CYCLES > GHOST_CYCLES ? DWELL_CYCLES : GHOST_CYCLES;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  typedef enum logic {GHOST, DWELL} state_t;
  state_t state, state_nx;
  logic [TW-1:0] timer;
  logic [2:0] idx;
  logic [FW-1:0] frame_cnt;
  logic blink_phase;
  logic [31:0] snap_digits, cur_digits;
  logic [7:0] snap_dp, snap_blink, cur_dp, cur_blink, lz;
  logic snap_lz, cur_lz, first, ghost_done, dwell_done, blank, run;
  logic [3:0] code;
  // digit 0's slot latches a fresh snapshot, so it must already see the live inputs
  always_comb begin
    first = idx == 3'd0;
    ghost_done = state == GHOST && timer == TW'(GHOST_CYCLES - 1);
    dwell_done = state == DWELL && timer == TW'(DWELL_CYCLES - 1);
    state_nx = ghost_done ? DWELL : dwell_done ? GHOST : state;
    cur_digits = first ? digits : snap_digits;
    cur_dp = first ? dp_mask : snap_dp;
    cur_blink = first ? blink_mask : snap_blink;
    cur_lz = first ? lz_blank_en : snap_lz;
    lz = '0;
    run = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      run = run && cur_digits[4*i +: 4] == 4'd0;
      lz[i] = run;
    end
    code = cur_digits[{idx, 2'b00} +: 4];
    blank = (cur_lz && lz[idx]) || (blink_phase && cur_blink[idx]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GHOST;
      timer <= '0;
      idx <= '0;
      frame_cnt <= '0;
      blink_phase <= 1'b0;
      snap_digits <= '0;
      snap_dp <= '0;
      snap_blink <= '0;
      snap_lz <= 1'b0;
      an <= 8'hFF;
      dec_code <= 4'hF;
      dp_n <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state <= state_nx;
      frame_start <= ghost_done && first;
      if (ghost_done) begin
        timer <= '0;
        an <= blank ? 8'hFF : ~(8'h01 << idx);
        dec_code <= blank ? 4'hF : code;
        dp_n <= blank || !cur_dp[idx];
        if (first) begin
          snap_digits <= digits;
          snap_dp <= dp_mask;
          snap_blink <= blink_mask;
          snap_lz <= lz_blank_en;
        end
      end else if (dwell_done) begin
        timer <= '0;
        idx <= idx + 3'd1;
        an <= 8'hFF;
        dec_code <= 4'hF;
        dp_n <= 1'b1;
        if (idx == 3'd7) begin
          frame_cnt <= frame_cnt == FW'(BLINK_FRAMES - 1) ? '0 : frame_cnt + FW'(1);
          blink_phase <= frame_cnt == FW'(BLINK_FRAMES - 1) ? !blink_phase : blink_phase;
        end
      end else begin
        timer <= timer + TW'(1);
      end
    end
  end
endmodule

// File: tb/tb_disp_scan_sched.sv
// tb_disp_scan_sched: scoreboard bench; stimulus queues per-cycle expectations, monitor compares.
module tb_disp_scan_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] digits = '0;
  logic [7:0] dp_mask = '0, blink_mask = '0;
  logic lz_blank_en = 1'b0;
  logic [7:0] an;
  logic [3:0] dec_code;
  logic dp_n, frame_start;
  int checks = 0, errors = 0;
  string test = "init";
  logic [13:0] q[$];

  disp_scan_sched #(.DWELL_CYCLES(4), .GHOST_CYCLES(1), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .digits(digits), .dp_mask(dp_mask), .blink_mask(blink_mask),
    .lz_blank_en(lz_blank_en), .an(an), .dec_code(dec_code), .dp_n(dp_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [13:0] e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({an, dec_code, dp_n, frame_start} !== e) begin
        errors++;
        $display("FAIL %s: an=%h dec=%h dp_n=%b fs=%b expected an=%h dec=%h dp_n=%b fs=%b",
                 test, an, dec_code, dp_n, frame_start, e[13:6], e[5:2], e[1], e[0]);
      end
    end
  end

  task automatic push_frame(input logic [7:0] lit, input logic [31:0] codes,
                            input logic [7:0] dp, input int n);
    int c = 0;
    for (int i = 0; i < 8; i++) begin
      if (c < n) q.push_back({8'hFF, 4'hF, 1'b1, 1'b0});
      c++;
      for (int k = 0; k < 4; k++) begin
        logic [7:0] a = lit[i] ? ~(8'h01 << i) : 8'hFF;
        logic [3:0] d = lit[i] ? codes[4*i +: 4] : 4'hF;
        logic p = lit[i] ? !dp[i] : 1'b1;
        if (c < n) q.push_back({a, d, p, i == 0 && k == 0});
        c++;
      end
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) return;
    end
    errors++;
    $display("FAIL %s: timeout with %0d expectations pending", test, q.size());
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    test = "scan";
    digits = 32'h87654321;
    do_reset();
    push_frame(8'hFF, 32'h87654321, 8'h00, 40);
    push_frame(8'hFF, 32'h87654321, 8'h00, 40);
    drain();

    test = "lz_705";
    digits = 32'h00000705;
    lz_blank_en = 1'b1;
    do_reset();
    push_frame(8'h07, 32'h00000705, 8'h00, 40);
    drain();

    test = "lz_zero";
    digits = 32'h00000000;
    do_reset();
    push_frame(8'h01, 32'h00000000, 8'h00, 40);
    drain();

    test = "blink";
    digits = 32'h87654321;
    lz_blank_en = 1'b0;
    blink_mask = 8'h01;
    do_reset();
    push_frame(8'hFF, 32'h87654321, 8'h00, 40);
    push_frame(8'hFF, 32'h87654321, 8'h00, 40);
    push_frame(8'hFE, 32'h87654321, 8'h00, 40);
    push_frame(8'hFE, 32'h87654321, 8'h00, 40);
    push_frame(8'hFF, 32'h87654321, 8'h00, 40);
    push_frame(8'hFF, 32'h87654321, 8'h00, 40);
    drain();

    test = "dp_snapshot";
    blink_mask = 8'h00;
    dp_mask = 8'h50;
    do_reset();
    push_frame(8'hFF, 32'h87654321, 8'h50, 40);
    push_frame(8'hFF, 32'h11111111, 8'h50, 40);
    repeat (12) @(negedge clk);
    digits = 32'h11111111;
    drain();

    test = "rst_mid";
    digits = 32'h87654321;
    dp_mask = 8'h00;
    do_reset();
    push_frame(8'hFF, 32'h87654321, 8'h00, 18);
    drain();
    do_reset();
    checks++;
    if (an !== 8'hFF) begin
      errors++;
      $display("FAIL %s: an=%h after rst", test, an);
    end
    checks++;
    if (dec_code !== 4'hF) begin
      errors++;
      $display("FAIL %s: dec=%h after rst", test, dec_code);
    end
    checks++;
    if (dp_n !== 1'b1) begin
      errors++;
      $display("FAIL %s: dp_n=%b after rst", test, dp_n);
    end
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL %s: fs=%b after rst", test, frame_start);
    end
    push_frame(8'hFF, 32'h87654321, 8'h00, 40);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
